// File: rtl/draw_board_bg_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg / vga_if
// Description : Shared VGA constants and the timing+colour bundle passed
//               between stages of the video pipeline.
// Revision    : 1.0 - initial release
// ============================================================================

package vga_pkg;
    localparam int          HOR_PIXELS       = 800;
    localparam int          VER_PIXELS       = 600;
    localparam logic [11:0] BACKGROUND_COLOR = 12'h444;
endpackage

interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    // Producer side of a pipeline link
    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    // Consumer side of a pipeline link
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_board_bg.sv
`default_nettype none
// ============================================================================
// Module      : draw_board_bg
// Description : Background stage. Paints screen edges and a CELLS x CELLS
//               board (grid, checker fill, cursor) behind later stages and
//               exports the cell coordinates of each output pixel.
//               Two-cycle latency, no dividers (running cell counters).
// Revision    : 1.0 - initial release
// ============================================================================

module draw_board_bg
    import vga_pkg::*;
#(
    parameter int unsigned BOARD_X0     = 64,
    parameter int unsigned BOARD_Y0     = 64,
    parameter int unsigned CELL_SIZE    = 32,
    parameter int unsigned CELLS        = 10,
    parameter int unsigned LINE_W       = 1,
    parameter int unsigned BORDER_W     = 4,
    parameter logic [11:0] GRID_COLOR   = 12'hfff,
    parameter logic [11:0] CELL_A       = 12'h03a,
    parameter logic [11:0] CELL_B       = 12'h025,
    parameter logic [11:0] CURSOR_COLOR = 12'hfa0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vga_if.slave            in,
    vga_if.master           out,
    input  wire logic [1:0] mode,
    input  wire logic [3:0] cursor_col,
    input  wire logic [3:0] cursor_row,
    output logic      [3:0] cell_col,
    output logic      [3:0] cell_row,
    output logic            in_board
);

    // Internal counters are 5 bits so that CELLS == 15 (closing line index)
    // never collides with the "outside" code.
    localparam logic [4:0]  OUTSIDE  = 5'h1f;
    localparam logic [4:0]  CELLS_C  = 5'(CELLS);
    localparam logic [3:0]  CELLS_4  = 4'(CELLS);
    localparam logic [10:0] X0       = 11'(BOARD_X0);
    localparam logic [10:0] Y0       = 11'(BOARD_Y0);
    localparam logic [10:0] CS_M1    = 11'(CELL_SIZE - 1);
    localparam logic [10:0] LW       = 11'(LINE_W);
    localparam logic [10:0] LW_M1    = 11'(LINE_W - 1);
    localparam logic [10:0] BW       = 11'(BORDER_W);
    localparam logic [10:0] RIGHT_E  = 11'(HOR_PIXELS - BORDER_W);
    localparam logic [10:0] BOTTOM_E = 11'(VER_PIXELS - BORDER_W);

    generate
        if (BOARD_X0 + CELLS * CELL_SIZE + LINE_W > HOR_PIXELS) begin : g_check_x
            $error("draw_board_bg: board exceeds HOR_PIXELS");
        end
        if (BOARD_Y0 + CELLS * CELL_SIZE + LINE_W > VER_PIXELS) begin : g_check_y
            $error("draw_board_bg: board exceeds VER_PIXELS");
        end
    endgenerate

    // One step of a cell counter: pixel-in-cell, then cell index, then the
    // closing line, then parked at OUTSIDE until re-armed by the caller.
    function automatic logic [15:0] step(input logic [4:0] c, input logic [10:0] p);
        logic [4:0]  cn;
        logic [10:0] pn;
        cn = c;
        pn = p;
        if (c < CELLS_C) begin
            if (p == CS_M1) begin
                pn = '0;
                cn = c + 5'd1;
            end else begin
                pn = p + 11'd1;
            end
        end else if (c == CELLS_C) begin
            if (p == LW_M1) begin
                pn = '0;
                cn = OUTSIDE;
            end else begin
                pn = p + 11'd1;
            end
        end
        return {cn, pn};
    endfunction

    // Upstream rgb is replaced by this stage
    logic unused_rgb;
    assign unused_rgb = ^in.rgb;

    // Shadow registers (frame-stable controls)
    logic [1:0]  mode_q, mode_d;
    logic [3:0]  cur_col_q, cur_col_d, cur_row_q, cur_row_d;
    // Stage 1
    logic [4:0]  col_q, col_d, row_q, row_d;
    logic [10:0] px_q, px_d, py_q, py_d;
    logic [10:0] s1_hcount_q, s1_hcount_d, s1_vcount_q, s1_vcount_d;
    logic        s1_hsync_q, s1_hsync_d, s1_vsync_q, s1_vsync_d;
    logic        s1_hblnk_q, s1_hblnk_d, s1_vblnk_q, s1_vblnk_d;
    logic        grid_q, grid_d, cur_hit_q, cur_hit_d, par_q, par_d;
    logic        s1_board_q, s1_board_d;
    logic [3:0]  s1_cell_col_q, s1_cell_col_d, s1_cell_row_q, s1_cell_row_d;
    // Stage 2
    logic [10:0] o_hcount_q, o_hcount_d, o_vcount_q, o_vcount_d;
    logic        o_hsync_q, o_hsync_d, o_vsync_q, o_vsync_d;
    logic        o_hblnk_q, o_hblnk_d, o_vblnk_q, o_vblnk_d;
    logic [11:0] o_rgb_q, o_rgb_d;
    logic [3:0]  o_cell_col_q, o_cell_col_d, o_cell_row_q, o_cell_row_d;
    logic        o_board_q, o_board_d;

    // Shadow sampling, cell counters and stage-1 flags
    always_comb begin
        mode_d    = mode_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        if (in.vblnk && !s1_vblnk_q) begin
            mode_d    = mode;
            cur_col_d = cursor_col;
            cur_row_d = cursor_row;
        end

        if (in.hcount == X0) begin
            col_d = 5'd0;
            px_d  = 11'd0;
        end else begin
            {col_d, px_d} = step(col_q, px_q);
        end

        row_d = row_q;
        py_d  = py_q;
        if (in.hcount == 11'd0) begin
            if (in.vcount == Y0) begin
                row_d = 5'd0;
                py_d  = 11'd0;
            end else begin
                {row_d, py_d} = step(row_q, py_q);
            end
        end

        s1_hcount_d   = in.hcount;
        s1_vcount_d   = in.vcount;
        s1_hsync_d    = in.hsync;
        s1_vsync_d    = in.vsync;
        s1_hblnk_d    = in.hblnk;
        s1_vblnk_d    = in.vblnk;
        s1_board_d    = (col_d <= CELLS_C) && (row_d <= CELLS_C);
        grid_d        = (px_d < LW) || (py_d < LW);
        par_d         = col_d[0] ^ row_d[0];
        cur_hit_d     = (col_d == {1'b0, cur_col_q}) && (row_d == {1'b0, cur_row_q})
                        && (cur_col_q < CELLS_4) && (cur_row_q < CELLS_4);
        s1_cell_col_d = (s1_board_d && col_d < CELLS_C && row_d < CELLS_C) ? col_d[3:0] : 4'hf;
        s1_cell_row_d = (s1_board_d && col_d < CELLS_C && row_d < CELLS_C) ? row_d[3:0] : 4'hf;
    end

    // Stage 2: colour priority and output alignment
    always_comb begin
        o_hcount_d   = s1_hcount_q;
        o_vcount_d   = s1_vcount_q;
        o_hsync_d    = s1_hsync_q;
        o_vsync_d    = s1_vsync_q;
        o_hblnk_d    = s1_hblnk_q;
        o_vblnk_d    = s1_vblnk_q;
        o_cell_col_d = s1_cell_col_q;
        o_cell_row_d = s1_cell_row_q;
        o_board_d    = s1_board_q;
        o_rgb_d      = BACKGROUND_COLOR;
        if (s1_vblnk_q || s1_hblnk_q)            o_rgb_d = 12'h000;
        else if (s1_vcount_q < BW)               o_rgb_d = 12'hff0;
        else if (s1_vcount_q >= BOTTOM_E)        o_rgb_d = 12'hf00;
        else if (s1_hcount_q < BW)               o_rgb_d = 12'h0f0;
        else if (s1_hcount_q >= RIGHT_E)         o_rgb_d = 12'h00f;
        else if (!s1_board_q || mode_q == 2'd0)  o_rgb_d = BACKGROUND_COLOR;
        else if (grid_q)                         o_rgb_d = GRID_COLOR;
        else if (mode_q == 2'd3 && cur_hit_q)    o_rgb_d = CURSOR_COLOR;
        else if (mode_q >= 2'd2)                 o_rgb_d = par_q ? CELL_B : CELL_A;
    end

    // All state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= 2'd0;
            cur_col_q     <= 4'd0;
            cur_row_q     <= 4'd0;
            col_q         <= OUTSIDE;
            row_q         <= OUTSIDE;
            px_q          <= '0;
            py_q          <= '0;
            s1_hcount_q   <= '0;
            s1_vcount_q   <= '0;
            s1_hsync_q    <= 1'b0;
            s1_vsync_q    <= 1'b0;
            s1_hblnk_q    <= 1'b0;
            s1_vblnk_q    <= 1'b0;
            grid_q        <= 1'b0;
            cur_hit_q     <= 1'b0;
            par_q         <= 1'b0;
            s1_board_q    <= 1'b0;
            s1_cell_col_q <= 4'hf;
            s1_cell_row_q <= 4'hf;
            o_hcount_q    <= '0;
            o_vcount_q    <= '0;
            o_hsync_q     <= 1'b0;
            o_vsync_q     <= 1'b0;
            o_hblnk_q     <= 1'b0;
            o_vblnk_q     <= 1'b0;
            o_rgb_q       <= 12'h000;
            o_cell_col_q  <= 4'hf;
            o_cell_row_q  <= 4'hf;
            o_board_q     <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            cur_col_q     <= cur_col_d;
            cur_row_q     <= cur_row_d;
            col_q         <= col_d;
            row_q         <= row_d;
            px_q          <= px_d;
            py_q          <= py_d;
            s1_hcount_q   <= s1_hcount_d;
            s1_vcount_q   <= s1_vcount_d;
            s1_hsync_q    <= s1_hsync_d;
            s1_vsync_q    <= s1_vsync_d;
            s1_hblnk_q    <= s1_hblnk_d;
            s1_vblnk_q    <= s1_vblnk_d;
            grid_q        <= grid_d;
            cur_hit_q     <= cur_hit_d;
            par_q         <= par_d;
            s1_board_q    <= s1_board_d;
            s1_cell_col_q <= s1_cell_col_d;
            s1_cell_row_q <= s1_cell_row_d;
            o_hcount_q    <= o_hcount_d;
            o_vcount_q    <= o_vcount_d;
            o_hsync_q     <= o_hsync_d;
            o_vsync_q     <= o_vsync_d;
            o_hblnk_q     <= o_hblnk_d;
            o_vblnk_q     <= o_vblnk_d;
            o_rgb_q       <= o_rgb_d;
            o_cell_col_q  <= o_cell_col_d;
            o_cell_row_q  <= o_cell_row_d;
            o_board_q     <= o_board_d;
        end
    end

    assign out.hcount = o_hcount_q;
    assign out.vcount = o_vcount_q;
    assign out.hsync  = o_hsync_q;
    assign out.vsync  = o_vsync_q;
    assign out.hblnk  = o_hblnk_q;
    assign out.vblnk  = o_vblnk_q;
    assign out.rgb    = o_rgb_q;
    assign cell_col   = o_cell_col_q;
    assign cell_row   = o_cell_row_q;
    assign in_board   = o_board_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_board_bg.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_board_bg
// Description : Directed self-checking bench for draw_board_bg.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_draw_board_bg;
    localparam logic [11:0] BG = 12'h444;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] cursor_col, cursor_row, cell_col, cell_row;
    logic       in_board;
    int         tests = 0;
    int         fails = 0;

    vga_if vin ();
    vga_if vout ();

    draw_board_bg dut (
        .clk        (clk),
        .rst        (rst),
        .in         (vin),
        .out        (vout),
        .mode       (mode),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .cell_col   (cell_col),
        .cell_row   (cell_row),
        .in_board   (in_board)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold one input pixel across a rising edge, return 1 ns after it
    task automatic drive(input int h, input int v, input logic hb, input logic vb);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = (h == 700);
        vin.vsync  = 1'b0;
        vin.rgb    = 12'habc;
        @(posedge clk);
        #1;
    endtask

    // Raise vblnk so the shadow controls are reloaded
    task automatic vpulse();
        drive(0, 0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b0);
    endtask

    // Walk the line counters to (x,y); out shows (x,y) on return
    task automatic to_pixel(input int x, input int y, input logic hb, input logic vb);
        int start;
        start = (y >= 64) ? 64 : y;
        for (int v = start; v < y; v++) drive(0, v, 1'b0, 1'b0);
        for (int h = 0; h < x; h++) drive(h, y, 1'b0, 1'b0);
        drive(x, y, hb, vb);
        drive(x + 1, y, 1'b0, 1'b0);
    endtask

    // Finish the line so the column counter parks outside the board
    task automatic finish_line(input int x, input int y);
        for (int h = x + 2; h < 400; h++) drive(h, y, 1'b0, 1'b0);
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
        to_pixel(x, y, 1'b0, 1'b0);
        check(tag, {4'h0, vout.rgb}, {4'h0, exp});
        finish_line(x, y);
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; cursor_col = 4'd0; cursor_row = 4'd0;
        drive(0, 0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b0);
        check("reset_rgb",      {4'h0, vout.rgb}, 16'h0);
        check("reset_cell_col", {12'h0, cell_col}, 16'hf);
        check("reset_cell_row", {12'h0, cell_row}, 16'hf);
        check("reset_in_board", {15'h0, in_board}, 16'h0);
        rst = 1'b0;

        // mode 1: grid only
        mode = 2'd1;
        vpulse();
        to_pixel(64, 64, 1'b0, 1'b0);
        check("grid_64_64",     {4'h0, vout.rgb}, 16'hfff);
        check("grid_64_board",  {15'h0, in_board}, 16'h1);
        check("grid_64_col",    {12'h0, cell_col}, 16'h0);
        finish_line(64, 64);
        pix("bg_65_65", 65, 65, BG);
        to_pixel(384, 100, 1'b0, 1'b0);
        check("close_384_rgb",   {4'h0, vout.rgb}, 16'hfff);
        check("close_384_board", {15'h0, in_board}, 16'h1);
        finish_line(384, 100);
        to_pixel(385, 100, 1'b0, 1'b0);
        check("out_385_rgb",   {4'h0, vout.rgb}, {4'h0, BG});
        check("out_385_board", {15'h0, in_board}, 16'h0);
        finish_line(385, 100);

        // asynchronous reset mid-frame
        to_pixel(300, 200, 1'b0, 1'b0);
        check("pre_rst_col", {12'h0, cell_col}, 16'h7);
        check("pre_rst_row", {12'h0, cell_row}, 16'h4);
        check("pre_rst_rgb", {4'h0, vout.rgb}, {4'h0, BG});
        #2 rst = 1'b1;
        #1;
        check("rst_async_rgb", {4'h0, vout.rgb}, 16'h0);
        check("rst_async_col", {12'h0, cell_col}, 16'hf);
        drive(302, 200, 1'b0, 1'b0);
        rst = 1'b0;
        drive(500, 200, 1'b0, 1'b0);
        drive(501, 200, 1'b0, 1'b0);
        check("post_rst_hcount", {5'h0, vout.hcount}, 16'd500);
        check("post_rst_vcount", {5'h0, vout.vcount}, 16'd200);
        finish_line(501, 200);

        // mode 2: checker
        mode = 2'd2;
        vpulse();
        pix("cell_a_70_70", 70, 70, 12'h03a);
        to_pixel(100, 70, 1'b0, 1'b0);
        check("cell_b_100_70", {4'h0, vout.rgb}, 16'h025);
        check("cell_b_col",    {12'h0, cell_col}, 16'h1);
        check("cell_b_row",    {12'h0, cell_row}, 16'h0);
        finish_line(100, 70);

        // mode 3: cursor, applied only after a vblnk rise
        mode = 2'd3; cursor_col = 4'd2; cursor_row = 4'd3;
        pix("cursor_pending", 130, 170, 12'h025);
        vpulse();
        pix("cursor_hit", 130, 170, 12'hfa0);
        cursor_col = 4'd12; cursor_row = 4'd0;
        vpulse();
        pix("cursor_off_2_3", 130, 170, 12'h025);
        pix("cursor_off_0_0", 70, 70, 12'h03a);

        // screen edges and blanking
        pix("edge_left_0",   0, 300, 12'h0f0);
        pix("edge_left_3",   3, 300, 12'h0f0);
        pix("edge_left_4",   4, 300, BG);
        pix("edge_top",      100, 0, 12'hff0);
        pix("edge_bottom",   100, 597, 12'hf00);
        pix("edge_right",    797, 300, 12'h00f);
        to_pixel(130, 170, 1'b1, 1'b0);
        check("hblank_zero", {4'h0, vout.rgb}, 16'h0);
        finish_line(130, 170);
        to_pixel(130, 170, 1'b0, 1'b1);
        check("vblank_zero", {4'h0, vout.rgb}, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
